// File: rtl/morse_sos_detector_pkg.sv
// morse_pkg: shared encodings for the Morse SOS detector (and the matching
// generator): character codes, FSM states, element values and the
// character-code classification rule.
package morse_pkg;

    // Char_Code values
    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_S     = 2'd1;
    localparam logic [1:0] CODE_O     = 2'd2;
    localparam logic [1:0] CODE_OTHER = 2'd3;

    // Element encoding inside the pattern buffer
    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int MAX_ELEMS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    // S = three dots, O = three dashes, anything else that fits is "other".
    function automatic logic [1:0] char_code(input logic [2:0] len, input logic [3:0] pat);
        if (len == 3'd3 && pat[2:0] == {3{DOT}})
            return CODE_S;
        else if (len == 3'd3 && pat[2:0] == {3{DASH}})
            return CODE_O;
        return CODE_OTHER;
    endfunction

endpackage

// File: rtl/ms_tick_timer.sv
// ms_tick_timer: millisecond interval timer.
//   CLK, RST  - clock, synchronous active-high reset
//   Clear     - restart the measurement (prescaler and ms count to 0)
//   Count_MS  - whole milliseconds since the last Clear, saturating
// A prescaler counts 0..T1MS; each wrap is one millisecond.
module ms_tick_timer #(
    parameter int T1MS = 49999,
    parameter int CW   = 16,
    parameter int MSW  = 10
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Clear,
    output logic [MSW-1:0] Count_MS
);

    logic [CW-1:0] count1;
    logic          tick;

    assign tick = (count1 == CW'(T1MS));

    always_ff @(posedge CLK) begin
        if (RST || Clear) begin
            count1   <= '0;
            Count_MS <= '0;
        end else begin
            count1 <= tick ? '0 : count1 + 1'b1;
            if (tick && Count_MS != '1)
                Count_MS <= Count_MS + 1'b1;
        end
    end

endmodule

// File: rtl/morse_sos_detector.sv
// morse_sos_detector: decodes Morse from a single pin and flags S,O,S.
//   CLK, RST      - clock, synchronous active-high reset
//   Enable        - detector runs while high; low returns it to a quiet idle
//   Pin_In        - asynchronous Morse input (MARK_LEVEL = key down)
//   Char_Valid    - 1-cycle pulse, a character was completed
//   Char_Code     - 0 none, 1 S, 2 O, 3 other; held between Char_Valid pulses
//   Char_Len      - element count of last character (1..4)
//   Char_Pattern  - elements of last character, bit0 first, 1 = dash
//   Error_Sig     - 1-cycle pulse, bad mark length or over-long character
//   Done_Sig      - 1-cycle pulse alongside the Char_Valid that completes S,O,S
module morse_sos_detector import morse_pkg::*; #(
    parameter int   T1MS        = 49999,
    parameter logic MARK_LEVEL  = 1'b0,
    parameter int   DOT_MIN     = 60,
    parameter int   DOT_MAX     = 140,
    parameter int   DASH_MIN    = 250,
    parameter int   DASH_MAX    = 450,
    parameter int   CHAR_GAP_MS = 200,
    parameter int   WORD_GAP_MS = 700
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Pin_In,
    output logic       Char_Valid,
    output logic [1:0] Char_Code,
    output logic [2:0] Char_Len,
    output logic [3:0] Char_Pattern,
    output logic       Error_Sig,
    output logic       Done_Sig
);

    localparam int MSW = 10;

    // Two synchronizer flops, then an edge-detect register.
    logic pin_s1, pin_s2, pin_s3;
    logic mark_now, mark_prev, mark_rise, mark_fall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pin_s1 <= ~MARK_LEVEL;
            pin_s2 <= ~MARK_LEVEL;
            pin_s3 <= ~MARK_LEVEL;
        end else begin
            pin_s1 <= Pin_In;
            pin_s2 <= pin_s1;
            pin_s3 <= pin_s2;
        end
    end

    assign mark_now  = (pin_s2 == MARK_LEVEL);
    assign mark_prev = (pin_s3 == MARK_LEVEL);
    assign mark_rise = mark_now & ~mark_prev;
    assign mark_fall = ~mark_now & mark_prev;

    state_t           state;
    logic [MSW-1:0]   count_ms;
    logic             tmr_clear;

    assign tmr_clear = mark_rise | mark_fall | (state == IDLE);

    ms_tick_timer #(.T1MS(T1MS), .CW(16), .MSW(MSW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .Clear    (tmr_clear),
        .Count_MS (count_ms)
    );

    // Element buffer
    logic [3:0] buf_pat;
    logic [2:0] buf_len;
    logic       ovf;

    // The 3-entry history window is the two stored codes plus the code being
    // finalized; only those three ever take part in the S,O,S match.
    logic [1:0][1:0] hist;    // [0] newest

    logic       is_dot, is_dash, gap_hit, word_hit, sos;
    logic [1:0] new_code;

    assign is_dot   = (count_ms >= MSW'(DOT_MIN))  && (count_ms <= MSW'(DOT_MAX));
    assign is_dash  = (count_ms >= MSW'(DASH_MIN)) && (count_ms <= MSW'(DASH_MAX));
    assign gap_hit  = (state == SPACE) && (count_ms == MSW'(CHAR_GAP_MS)) && (buf_len != 3'd0);
    assign word_hit = (count_ms == MSW'(WORD_GAP_MS));
    assign new_code = char_code(buf_len, buf_pat);
    assign sos      = (hist[1] == CODE_S) && (hist[0] == CODE_O) && (new_code == CODE_S);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            buf_pat      <= '0;
            buf_len      <= '0;
            ovf          <= 1'b0;
            hist         <= '0;
            Char_Valid   <= 1'b0;
            Char_Code    <= CODE_NONE;
            Char_Len     <= '0;
            Char_Pattern <= '0;
            Error_Sig    <= 1'b0;
            Done_Sig     <= 1'b0;
        end else begin
            Char_Valid <= 1'b0;
            Error_Sig  <= 1'b0;
            Done_Sig   <= 1'b0;

            if (!Enable) begin
                // Disabled: same quiet state as after reset; pulses are dropped.
                state        <= IDLE;
                buf_pat      <= '0;
                buf_len      <= '0;
                ovf          <= 1'b0;
                hist         <= '0;
                Char_Code    <= CODE_NONE;
                Char_Len     <= '0;
                Char_Pattern <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mark_rise) begin
                            state   <= MARK;
                            buf_pat <= '0;
                            buf_len <= '0;
                            ovf     <= 1'b0;
                        end
                    end

                    MARK: begin
                        if (mark_fall) begin
                            if (is_dot || is_dash) begin
                                if (buf_len == 3'(MAX_ELEMS)) begin
                                    ovf <= 1'b1;
                                end else begin
                                    buf_pat[buf_len[1:0]] <= is_dash ? DASH : DOT;
                                    buf_len               <= buf_len + 3'd1;
                                end
                                state <= SPACE;
                            end else begin
                                Error_Sig <= 1'b1;
                                buf_pat   <= '0;
                                buf_len   <= '0;
                                ovf       <= 1'b0;
                                hist      <= '0;
                                state     <= IDLE;
                            end
                        end
                    end

                    SPACE: begin
                        // Finalize first; a mark starting on the same cycle
                        // then begins a fresh character.
                        if (gap_hit) begin
                            if (ovf) begin
                                Error_Sig <= 1'b1;
                                hist      <= '0;
                            end else begin
                                Char_Valid   <= 1'b1;
                                Char_Code    <= new_code;
                                Char_Len     <= buf_len;
                                Char_Pattern <= buf_pat;
                                if (sos) begin
                                    Done_Sig <= 1'b1;
                                    hist     <= '0;
                                end else begin
                                    hist <= {hist[0], new_code};
                                end
                            end
                            buf_pat <= '0;
                            buf_len <= '0;
                            ovf     <= 1'b0;
                        end

                        if (mark_rise) begin
                            state <= MARK;
                        end else if (word_hit) begin
                            state <= IDLE;
                            hist  <= '0;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_sos_detector.sv
// Bench for morse_sos_detector. Stimulus is issued as whole characters; a
// character-level reference model pushes the expected event (character,
// error, detect) into a queue and a monitor compares every DUT pulse against it.
module tb_morse_sos_detector;
    import morse_pkg::*;

    localparam int   T1MS = 1;
    localparam int   CPM  = T1MS + 1;     // clocks per ms
    localparam logic MLVL = 1'b0;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Enable = 1'b0;
    logic       Pin_In = ~MLVL;
    logic       Char_Valid, Error_Sig, Done_Sig;
    logic [1:0] Char_Code;
    logic [2:0] Char_Len;
    logic [3:0] Char_Pattern;

    always #5 CLK = ~CLK;

    morse_sos_detector #(.T1MS(T1MS), .MARK_LEVEL(MLVL)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Enable       (Enable),
        .Pin_In       (Pin_In),
        .Char_Valid   (Char_Valid),
        .Char_Code    (Char_Code),
        .Char_Len     (Char_Len),
        .Char_Pattern (Char_Pattern),
        .Error_Sig    (Error_Sig),
        .Done_Sig     (Done_Sig)
    );

    typedef struct {
        bit         err;
        logic [1:0] code;
        logic [2:0] len;
        logic [3:0] pat;
        bit         done;
    } ev_t;

    ev_t expq[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Reference model state: received codes since last clear, last character shown
    logic [1:0] m_hist[$];
    logic [1:0] m_code = CODE_NONE;
    logic [2:0] m_len  = '0;
    logic [3:0] m_pat  = '0;

    // Duration ranges in ms (directed values first, widened for random)
    int dot_lo = 100, dot_hi = 100, dash_lo = 300, dash_hi = 300;
    int gap_lo = 50,  gap_hi = 50,  bad_lo  = 180, bad_hi  = 180;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rng(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Character-level model of one transmitted character.
    task automatic model_char(input int n, input logic [4:0] p, input bit bad, input int gap);
        ev_t        e;
        logic [1:0] c;
        int         k;
        e = '{1'b0, CODE_NONE, 3'd0, 4'd0, 1'b0};
        if (bad || n > 4) begin
            e.err  = 1'b1;
            m_hist.delete();
        end else begin
            if (n == 3 && p[2:0] == 3'b000)      c = CODE_S;
            else if (n == 3 && p[2:0] == 3'b111) c = CODE_O;
            else                                 c = CODE_OTHER;
            m_hist.push_back(c);
            k = m_hist.size();
            e.done = (k >= 3) && m_hist[k-3] == CODE_S && m_hist[k-2] == CODE_O && m_hist[k-1] == CODE_S;
            if (e.done) m_hist.delete();
            m_code = c;
            m_len  = 3'(n);
            m_pat  = p[3:0] & 4'((1 << n) - 1);
        end
        e.code = m_code;
        e.len  = m_len;
        e.pat  = m_pat;
        expq.push_back(e);
        if (gap >= 700) m_hist.delete();
    endtask

    task automatic hold(input bit mark, input int ms);
        Pin_In = mark ? MLVL : ~MLVL;
        repeat (ms * CPM) @(negedge CLK);
    endtask

    // n elements from p (bit i = element i, 1 = dash); if bad, the last mark
    // has an illegal length. gap = space after the last element.
    task automatic send_char(input int n, input logic [4:0] p, input bit bad, input int gap);
        model_char(n, p, bad, gap);
        for (int i = 0; i < n; i++) begin
            if (bad && i == n - 1) hold(1'b1, rng(bad_lo, bad_hi));
            else if (p[i])         hold(1'b1, rng(dash_lo, dash_hi));
            else                   hold(1'b1, rng(dot_lo, dot_hi));
            hold(1'b0, (i == n - 1) ? gap : rng(gap_lo, gap_hi));
        end
    endtask

    task automatic send_s(input int gap);
        send_char(3, 5'b00000, 1'b0, gap);
    endtask

    task automatic send_o(input int gap);
        send_char(3, 5'b00111, 1'b0, gap);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, Char_Valid, 0);
        check({tag, "_error"}, Error_Sig, 0);
        check({tag, "_done"},  Done_Sig, 0);
        check({tag, "_code"},  Char_Code, 0);
        check({tag, "_len"},   Char_Len, 0);
        check({tag, "_pat"},   Char_Pattern, 0);
    endtask

    // First dot and half of the second dot of an S, then RST or Enable drop.
    task automatic abort_s(input bit use_rst);
        hold(1'b1, 100);
        hold(1'b0, 50);
        hold(1'b1, 50);
        if (use_rst) RST = 1'b1;
        else         Enable = 1'b0;
        Pin_In = ~MLVL;
        repeat (4) @(negedge CLK);
        check_quiet(use_rst ? "abort_rst" : "abort_en");
        RST    = 1'b0;
        Enable = 1'b1;
        m_hist.delete();
        m_code = CODE_NONE;
        m_len  = '0;
        m_pat  = '0;
        hold(1'b0, 300);
    endtask

    // Monitor: every DUT pulse must match the next expected event.
    always @(negedge CLK) begin
        ev_t e;
        if (Char_Valid && Error_Sig) begin
            n_vec++;
            n_bad++;
            $display("FAIL valid_and_error: both asserted, required exclusive");
        end
        if (Char_Valid || Error_Sig || Done_Sig) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_event: valid=%b error=%b done=%b, none expected",
                         Char_Valid, Error_Sig, Done_Sig);
            end else begin
                e = expq.pop_front();
                check("ev_valid", Char_Valid, !e.err);
                check("ev_error", Error_Sig, e.err);
                check("ev_done",  Done_Sig, e.done);
                check("ev_code",  Char_Code, e.code);
                check("ev_len",   Char_Len, e.len);
                check("ev_pat",   Char_Pattern, e.pat);
            end
        end
    end

    initial begin
        int         r, n;
        logic [4:0] p;

        repeat (4) @(negedge CLK);
        check_quiet("reset");
        RST    = 1'b0;
        Enable = 1'b1;
        hold(1'b0, 20);

        // Single S
        send_s(250);
        // S O S O S: one detect only (preceding S makes history S,S,O,S)
        send_s(250); send_o(250); send_s(250); send_o(250); send_s(750);
        // Bad mark clears history: S O <bad> S gives no detect
        send_s(250); send_o(250);
        send_char(1, 5'b0, 1'b1, 300);
        send_s(750);
        // Word gap clears history
        send_s(250); send_o(800); send_s(750);
        // Five dots: overflow error, Char_* held from the last S
        send_char(5, 5'b0, 1'b0, 250);
        // Reset, then Enable drop, mid final S; full SOS afterwards
        send_s(250); send_o(250); abort_s(1'b1);
        send_s(250); send_o(250); send_s(750);
        send_s(250); send_o(250); abort_s(1'b0);
        send_s(250); send_o(250); send_s(750);

        // Random characters
        dot_lo = 70;   dot_hi = 130;  dash_lo = 270; dash_hi = 430;
        gap_lo = 30;   gap_hi = 150;  bad_lo  = 160; bad_hi  = 230;
        for (int i = 0; i < 8; i++) begin
            r = rng(0, 7);
            n = (rng(0, 3) == 0) ? 750 : rng(210, 300);
            case (r)
                0, 1, 2: send_s(n);
                3, 4:    send_o(n);
                5: begin
                    p = 5'($urandom);
                    send_char(rng(1, 4), p, 1'b0, n);
                end
                6: send_char(5, 5'($urandom), 1'b0, n);
                default: send_char(rng(1, 3), 5'($urandom), 1'b1, n);
            endcase
        end

        hold(1'b0, 300);
        check("pending_events", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
